// File: rtl/scroll_buffer.sv
// Programmable 7-segment message store: loads hex nibbles over a valid/ready port,
// then scrolls them right-to-left across DIGITS digits on each scroll tick.
module scroll_buffer #(
   parameter int DEPTH  = 16,
   parameter int DIGITS = 4,
   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          wr_valid,
   input  logic [3:0]    wr_data,
   input  logic          wr_last,
   output logic          wr_ready,
   input  logic          tick_scroll,
   input  logic [SW-1:0] dig_sel,
   output logic [3:0]    value,
   output logic          off_display,
   output logic          wrap
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(DEPTH + DIGITS);
   localparam int IW = OW + 1;

   localparam logic [0:0] ST_LOAD   = 1'b0;
   localparam logic [0:0] ST_SCROLL = 1'b1;

   logic [3:0]    mem [DEPTH];

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [LW-1:0] len_q, len_d;
   logic [OW-1:0] offset_q, offset_d;
   logic [3:0]    value_q, value_d;
   logic          off_display_q, off_display_d;
   logic          wrap_q, wrap_d;
   logic          mem_we;

   logic [IW-1:0] idx;
   logic [IW-1:0] p_last;
   logic          idx_blank;

   // Position in the message for the scanned digit; negative while the leading blanks pass.
   assign idx       = IW'(offset_q) + IW'(dig_sel) - IW'(DIGITS);
   assign p_last    = IW'(len_q) + IW'(DIGITS - 1);
   assign idx_blank = idx[IW-1] || (idx >= IW'(len_q));

   always_comb begin
      state_d       = state_q;
      wptr_d        = wptr_q;
      len_d         = len_q;
      offset_d      = offset_q;
      value_d       = value_q;
      off_display_d = 1'b1;
      wrap_d        = 1'b0;
      mem_we        = 1'b0;

      if (clear) begin
         state_d  = ST_LOAD;
         wptr_d   = '0;
         len_d    = '0;
         offset_d = '0;
      end else if (state_q == ST_LOAD) begin
         if (wr_valid) begin
            mem_we = rst;
            wptr_d = wptr_q + AW'(1);
            // A full buffer terminates the message even without wr_last.
            if (wr_last || (wptr_q == AW'(DEPTH - 1))) begin
               len_d    = LW'(wptr_q) + LW'(1);
               offset_d = '0;
               state_d  = ST_SCROLL;
            end
         end
      end else begin
         if (!idx_blank) begin
            value_d       = mem[idx[AW-1:0]];
            off_display_d = 1'b0;
         end
         if (tick_scroll) begin
            if (IW'(offset_q) == p_last) begin
               offset_d = '0;
               wrap_d   = 1'b1;
            end else begin
               offset_d = offset_q + OW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_LOAD;
         wptr_q        <= '0;
         len_q         <= '0;
         offset_q      <= '0;
         value_q       <= 4'h0;
         off_display_q <= 1'b1;
         wrap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wptr_q        <= wptr_d;
         len_q         <= len_d;
         offset_q      <= offset_d;
         value_q       <= value_d;
         off_display_q <= off_display_d;
         wrap_q        <= wrap_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr_q] <= wr_data;
      end
   end

   assign wr_ready    = (state_q == ST_LOAD);
   assign value       = value_q;
   assign off_display = off_display_q;
   assign wrap        = wrap_q;

endmodule

// File: doc/scroll_buffer.md
Name: scroll_buffer

Overview:
- Programmable message store that feeds the 7-segment scan/driver stage in place of a hard-coded banner sequence.
- Accepts a message of hex nibbles over a valid/ready write port, then scrolls it across DIGITS digits on each scroll tick.
- For the digit currently selected by the scan stage, it outputs the nibble and a blank flag, which drive the driver's value and off_display inputs.

Parameters:
- DEPTH, 16, maximum message length in nibbles; must be a power of 2, at least 2.
- DIGITS, 4, number of display digits; dig_sel width is clog2(DIGITS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- clear  in  1  synchronous return to LOAD and discard the message
- wr_valid  in  1  write nibble valid
- wr_data  in  4  write nibble
- wr_last  in  1  marks the final nibble of the message, qualified by wr_valid
- wr_ready  out  1  buffer accepts a write
- tick_scroll  in  1  one-cycle scroll strobe from the clock divider
- dig_sel  in  clog2(DIGITS)  digit currently scanned; index DIGITS-1 is the entry digit
- value  out  4  nibble for the selected digit
- off_display  out  1  blank the selected digit
- wrap  out  1  one-cycle pulse when the scroll offset returns to 0

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=LOAD, wptr=0, len=0, offset=0.
  - value=0, off_display=1, wrap=0, wr_ready=1.
  - Memory contents are don't-care.
- Priority order: rst, then clear, then normal operation.
- clear=1:
  - next state is LOAD, wptr=0, len=0, offset=0, off_display=1, wrap=0.
  - A write presented in the same cycle is dropped.
- LOAD state:
  - wr_ready=1 (combinational from state).
  - Accept occurs when wr_valid & wr_ready: mem[wptr]<=wr_data, wptr<=wptr+1.
  - If the accepted write has wr_last=1, or wptr==DEPTH-1: len<=wptr+1, offset<=0, state<=SCROLL.
  - The DEPTH-th write auto-terminates the message even without wr_last.
  - tick_scroll is ignored. off_display is held at 1.
- SCROLL state:
  - wr_ready=0; wr_valid is ignored and memory is unchanged.
  - Virtual stream is DIGITS leading blanks followed by len nibbles; period P = len + DIGITS.
  - offset width is clog2(DEPTH+DIGITS).
  - On tick_scroll: if offset==P-1, then offset<=0 and wrap<=1 for exactly one cycle; otherwise offset<=offset+1.
- Window mapping:
  - idx = offset - DIGITS + dig_sel, computed signed at offset width plus 1.
  - Blank when idx<0 or idx>=len.
  - Not blank: value<=mem[idx], off_display<=0.
  - Blank: off_display<=1 and value holds its previous value.
  - Characters enter at dig_sel=DIGITS-1 and move toward dig_sel=0.
- Latency:
  - value and off_display are registered, 1 cycle after dig_sel/offset.
  - When tick_scroll and a dig_sel change occur together, the output uses the pre-increment offset; the new offset is visible on the next cycle.
- Boundaries:
  - len=0 never occurs in SCROLL, because entry requires at least one accepted write.
  - len=DEPTH gives P=DEPTH+DIGITS; offset never exceeds P-1.
  - The transition cycle into SCROLL outputs blank.
  - Reset or clear mid-scroll blanks from the next cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs → off_display=1, value=0, wr_ready=1, wrap=0. Ticks while in LOAD leave offset at 0.
- Full load:
  - Write 0x0..0xF with wr_last on 0xF → wr_ready=0 the cycle after the 16th accept; at offset 0 all digits are blank.
  - After 1 tick: dig_sel=3 → value=0x0, off_display=0; dig_sel 0..2 blank.
  - After 4 ticks: dig_sel 0..3 → 0x0, 0x1, 0x2, 0x3.
- Wrap with len=16:
  - At offset 19: dig_sel=0 → 0xF, dig_sel 1..3 blank.
  - The 20th tick → wrap=1 for one cycle, offset=0, all digits blank.
- Short message A, B, C (wr_last on C), P=7:
  - At offset 4: dig_sel 0,1,2 → A, B, C; dig_sel=3 blank.
  - At offset 6: dig_sel=0 → C, others blank.
  - The 7th tick → wrap.
- Auto-terminate: 16 writes with wr_last=0 → enters SCROLL with len=16. A 17th write held valid is not accepted and memory is unchanged.
- Clear mid-scroll at offset 5 with wr_valid=1, wr_data=0x7:
  - Next cycle: LOAD, wr_ready=1, off_display=1, write dropped.
  - A subsequent single write 0x9 with wr_last → len=1, P=5; at offset 4, dig_sel=0 → 0x9.
